hazard_control_unit: RTL

Pipeline sequencer for the 5-stage core, sitting beside the fetch stage and the IF/ID and ID/EX registers. It detects load-use hazards, honours data-memory stall requests and applies taken-branch redirects. It drives PC load, the IF mux select, the IF/ID load and flush, ID/EX bubble insertion and a global hold. It also drains and halts the pipeline on ECALL and keeps saturating performance counters.

---
 rtl/hazard_control_unit_pkg.sv | 16 +
 rtl/hazard_control_unit_if.sv | 44 ++++
 rtl/hazard_control_unit_load_use_detector.sv | 19 +
 rtl/hazard_control_unit.sv | 131 +++++++++++++
 4 files changed

// File: rtl/hazard_control_unit_pkg.sv
// Shared types and sizing for the pipeline sequencer.
package pipeline_ctrl_pkg;

    localparam int unsigned REG_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } ctrl_state_t;

    function automatic int unsigned drain_cnt_width(input int unsigned drain_cycles);
        return $clog2(drain_cycles + 1);
    endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Hazard inputs and pipeline control outputs of the sequencer.
interface hazard_control_unit_if #(
    parameter int unsigned CNT_WIDTH = 16
);
    import pipeline_ctrl_pkg::*;

    logic                      id_ex_mem_read;
    logic [REG_ADDR_WIDTH-1:0] id_ex_rd;
    logic [REG_ADDR_WIDTH-1:0] if_id_rs1;
    logic [REG_ADDR_WIDTH-1:0] if_id_rs2;
    logic                      if_id_uses_rs1;
    logic                      if_id_uses_rs2;
    logic                      if_id_is_ecall;
    logic                      branch_taken;
    logic                      mem_stall;

    logic                      mux_sel;
    logic                      load_pc;
    logic                      load_if_id_register;
    logic                      if_flush;
    logic                      id_ex_flush;
    logic                      pipe_hold;
    logic                      halted;
    logic [CNT_WIDTH-1:0]      stall_count;
    logic [CNT_WIDTH-1:0]      flush_count;

    // master: the sequencer itself
    modport master (
        input  id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2,
               if_id_uses_rs1, if_id_uses_rs2, if_id_is_ecall,
               branch_taken, mem_stall,
        output mux_sel, load_pc, load_if_id_register, if_flush,
               id_ex_flush, pipe_hold, halted, stall_count, flush_count
    );

    modport slave (
        output id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2,
               if_id_uses_rs1, if_id_uses_rs2, if_id_is_ecall,
               branch_taken, mem_stall,
        input  mux_sel, load_pc, load_if_id_register, if_flush,
               id_ex_flush, pipe_hold, halted, stall_count, flush_count
    );

endinterface

// File: rtl/hazard_control_unit_load_use_detector.sv
// Combinational load-use hazard compare between ID/EX and IF/ID.
module load_use_detector
    import pipeline_ctrl_pkg::*;
(
    input  logic                      id_ex_mem_read,
    input  logic [REG_ADDR_WIDTH-1:0] id_ex_rd,
    input  logic [REG_ADDR_WIDTH-1:0] if_id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] if_id_rs2,
    input  logic                      if_id_uses_rs1,
    input  logic                      if_id_uses_rs2,
    output logic                      load_use
);

    // x0 is hardwired zero, so a load targeting it never creates a hazard
    assign load_use = id_ex_mem_read && (id_ex_rd != '0) &&
                      ((if_id_uses_rs1 && (if_id_rs1 == id_ex_rd)) ||
                       (if_id_uses_rs2 && (if_id_rs2 == id_ex_rd)));

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer: hazard stalls, branch redirects, ECALL drain/halt
// and saturating performance counters.
module hazard_control_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    hazard_control_unit_if.master hz
);

    localparam int unsigned DCW = drain_cnt_width(DRAIN_CYCLES);

    ctrl_state_t          state;
    logic [DCW-1:0]       drain_cnt;
    logic [CNT_WIDTH-1:0] stall_cnt;
    logic [CNT_WIDTH-1:0] flush_cnt;

    logic load_use;
    logic mux_sel_c, load_pc_c, load_if_id_c, if_flush_c, id_ex_flush_c, pipe_hold_c;
    logic redirect, stall_event, ecall_take;

    load_use_detector u_load_use_detector (
        .id_ex_mem_read (hz.id_ex_mem_read),
        .id_ex_rd       (hz.id_ex_rd),
        .if_id_rs1      (hz.if_id_rs1),
        .if_id_rs2      (hz.if_id_rs2),
        .if_id_uses_rs1 (hz.if_id_uses_rs1),
        .if_id_uses_rs2 (hz.if_id_uses_rs2),
        .load_use       (load_use)
    );

    always_comb begin
        mux_sel_c     = 1'b0;
        load_pc_c     = 1'b0;
        load_if_id_c  = 1'b0;
        if_flush_c    = 1'b0;
        id_ex_flush_c = 1'b0;
        pipe_hold_c   = 1'b0;
        redirect      = 1'b0;
        stall_event   = 1'b0;
        ecall_take    = 1'b0;
        if (!reset) begin
            if_flush_c    = 1'b1;
            id_ex_flush_c = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (hz.mem_stall) begin
                        pipe_hold_c = 1'b1;
                        stall_event = 1'b1;
                    end else if (hz.branch_taken) begin
                        redirect = 1'b1;
                    end else if (load_use) begin
                        id_ex_flush_c = 1'b1;
                        stall_event   = 1'b1;
                    end else if (hz.if_id_is_ecall) begin
                        id_ex_flush_c = 1'b1;
                        ecall_take    = 1'b1;
                    end else begin
                        load_pc_c    = 1'b1;
                        load_if_id_c = 1'b1;
                    end
                end
                DRAIN: begin
                    id_ex_flush_c = 1'b1;
                    if (hz.mem_stall) begin
                        pipe_hold_c = 1'b1;
                        stall_event = 1'b1;
                    end else if (hz.branch_taken) begin
                        redirect = 1'b1;
                    end
                end
                default: id_ex_flush_c = 1'b1;
            endcase
            if (redirect) begin
                mux_sel_c     = 1'b1;
                load_pc_c     = 1'b1;
                load_if_id_c  = 1'b1;
                if_flush_c    = 1'b1;
                id_ex_flush_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            drain_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_event && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (redirect && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
            case (state)
                RUN: begin
                    if (ecall_take) begin
                        state     <= (DRAIN_CYCLES == 0) ? HALTED : DRAIN;
                        drain_cnt <= DCW'(DRAIN_CYCLES);
                    end
                end
                DRAIN: begin
                    if (redirect) begin
                        state     <= RUN;
                        drain_cnt <= '0;
                    end else if (!hz.mem_stall) begin
                        drain_cnt <= drain_cnt - 1'b1;
                        if (drain_cnt == DCW'(1))
                            state <= HALTED;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hz.mux_sel             = mux_sel_c;
    assign hz.load_pc             = load_pc_c;
    assign hz.load_if_id_register = load_if_id_c;
    assign hz.if_flush            = if_flush_c;
    assign hz.id_ex_flush         = id_ex_flush_c;
    assign hz.pipe_hold           = pipe_hold_c;
    assign hz.halted              = reset && (state == HALTED);
    assign hz.stall_count         = stall_cnt;
    assign hz.flush_count         = flush_cnt;

endmodule
